// File: rtl/ctrl_sequencer_if.sv
// Fetch/decode/execute control bundle between ctrl_sequencer and the CPU memory/datapath.
// Optional CTRL_SEQ_IRQ_EN adds the irq/irq_ack pair.
interface ctrl_sequencer_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned FLAG_W  = 4,
  parameter int unsigned USTEP_W = 4
);
  logic [INSTR_W-1:0] instr;
  logic               mem_ready;
  logic [FLAG_W-1:0]  status;
  logic               stall;
  logic [2:0]         state;
  logic               fetch_req;
  logic [INSTR_W-1:0] ir_q;
  logic [OPC_W-1:0]   opcode_q;
  logic [USTEP_W-1:0] ustep;
  logic               branch_taken;
  logic               instr_done;
  logic               illegal_op;
`ifdef CTRL_SEQ_IRQ_EN
  logic               irq;
  logic               irq_ack;

  modport master (
    input  instr, mem_ready, status, stall, irq,
    output state, fetch_req, ir_q, opcode_q, ustep, branch_taken, instr_done, illegal_op, irq_ack
  );
  modport slave (
    output instr, mem_ready, status, stall, irq,
    input  state, fetch_req, ir_q, opcode_q, ustep, branch_taken, instr_done, illegal_op, irq_ack
  );
`else
  modport master (
    input  instr, mem_ready, status, stall,
    output state, fetch_req, ir_q, opcode_q, ustep, branch_taken, instr_done, illegal_op
  );
  modport slave (
    output instr, mem_ready, status, stall,
    input  state, fetch_req, ir_q, opcode_q, ustep, branch_taken, instr_done, illegal_op
  );
`endif
endinterface

// File: rtl/ctrl_sequencer.sv
// Registered fetch/decode/execute control sequencer with micro-step counter for the 16-bit CPU.
// Define CTRL_SEQ_IRQ_EN to enable interrupt entry at instruction boundaries.
module ctrl_sequencer #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned FLAG_W  = 4,
  parameter int unsigned USTEP_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_IRQ    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [OPC_W-1:0]   opcode_q;
  logic [USTEP_W-1:0] ustep_q, ustep_d;
  logic [2:0]         len_q, len_d;
  logic               branch_q, br_d;
  logic               opc_legal;
  logic               last_exec;
  logic               irq_take;
  logic               fetch_req, instr_done, illegal_op;
  logic               status_unused;

  assign status_unused = bus.status[0];
  assign opc_legal     = 32'(opcode_q) < 32'd16;
  assign last_exec     = (ustep_q == USTEP_W'(len_q - 3'd1));

`ifdef CTRL_SEQ_IRQ_EN
  logic irq_ack;
  assign irq_take    = bus.irq;
  assign bus.irq_ack = irq_ack;
`else
  assign irq_take = 1'b0;
`endif

  // Instruction length in EXEC cycles; conditional branches use flags seen during DECODE.
  always_comb begin
    br_d  = 1'b0;
    len_d = 3'd1;
    if (opc_legal) begin
      case (opcode_q[3:0])
        4'h0, 4'h1, 4'h5, 4'h6: len_d = 3'd1;
        4'h2, 4'h3, 4'h4:       len_d = 3'd3;
        4'h7, 4'h8, 4'h9, 4'hB: len_d = 3'd4;
        4'hA:                   len_d = 3'd6;
        4'hC:                   len_d = 3'd2;
        4'hD: begin br_d = bus.status[1]; len_d = bus.status[1] ? 3'd3 : 3'd1; end
        4'hE: begin br_d = bus.status[3]; len_d = bus.status[3] ? 3'd3 : 3'd1; end
        4'hF: begin br_d = bus.status[2]; len_d = bus.status[2] ? 3'd3 : 3'd1; end
        default: len_d = 3'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ustep_q  <= '0;
      ir_q     <= '0;
      opcode_q <= '0;
      len_q    <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ustep_q <= ustep_d;
      if (state_q == S_FETCH && bus.mem_ready) begin
        ir_q     <= bus.instr;
        opcode_q <= bus.instr[INSTR_W-1 -: OPC_W];
      end
      if (state_q == S_DECODE) begin
        len_q    <= len_d;
        branch_q <= br_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ustep_d = ustep_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXEC;
        ustep_d = '0;
      end
      S_EXEC: begin
        if (!bus.stall) begin
          if (last_exec) begin
            ustep_d = '0;
            state_d = irq_take ? S_IRQ : S_FETCH;
          end else begin
            ustep_d = ustep_q + USTEP_W'(1);
          end
        end
      end
`ifdef CTRL_SEQ_IRQ_EN
      S_IRQ: begin
        if (!bus.stall) begin
          if (ustep_q == USTEP_W'(3)) begin
            ustep_d = '0;
            state_d = S_FETCH;
          end else begin
            ustep_d = ustep_q + USTEP_W'(1);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_req  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
`ifdef CTRL_SEQ_IRQ_EN
    irq_ack    = 1'b0;
`endif
    case (state_q)
      S_FETCH:  fetch_req  = 1'b1;
      S_DECODE: illegal_op = !opc_legal;
      S_EXEC:   instr_done = !bus.stall && last_exec;
`ifdef CTRL_SEQ_IRQ_EN
      S_IRQ:    irq_ack    = !bus.stall && (ustep_q == USTEP_W'(3));
`endif
      default: ;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.fetch_req    = fetch_req;
  assign bus.ir_q         = ir_q;
  assign bus.opcode_q     = opcode_q;
  assign bus.ustep        = ustep_q;
  assign bus.branch_taken = branch_q;
  assign bus.instr_done   = instr_done;
  assign bus.illegal_op   = illegal_op;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: a timing model of each instruction predicts
// illegal_op / instr_done / irq_ack events, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_ctrl_sequencer;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned USTEP_W = 4;
  localparam int K_ILL = 0, K_DONE = 1, K_ACK = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] ir;
    int          opc;
    bit          br;
    int          us;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_drv = 1'b0;
  logic        ack_s;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_ir = '0;
  exp_t        sbq[$];

  ctrl_sequencer_if #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .FLAG_W(FLAG_W), .USTEP_W(USTEP_W)) bus ();

  ctrl_sequencer #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .FLAG_W(FLAG_W), .USTEP_W(USTEP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef CTRL_SEQ_IRQ_EN
  assign bus.irq = irq_drv;
  assign ack_s   = bus.irq_ack;
`else
  assign ack_s   = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ref_len(input int opc, input logic [3:0] fl, output bit taken);
    int base[13];
    base  = '{1, 1, 3, 3, 3, 1, 1, 4, 4, 4, 6, 4, 2};
    taken = 1'b0;
    if (opc >= 16) return 1;
    if (opc < 13) return base[opc];
    case (opc)
      13:      taken = fl[1];
      14:      taken = fl[3];
      default: taken = fl[2];
    endcase
    return taken ? 3 : 1;
  endfunction

  task automatic rand_inputs();
    bus.instr     = 16'($urandom);
    bus.status    = 4'($urandom);
    bus.stall     = 1'($urandom_range(1));
    bus.mem_ready = 1'($urandom_range(1));
    irq_drv       = 1'($urandom_range(1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, bus.state, 0);
    chk({tag, "_fetch_req"}, bus.fetch_req, 0);
    chk({tag, "_ir_q"}, bus.ir_q, 0);
    chk({tag, "_opcode_q"}, bus.opcode_q, 0);
    chk({tag, "_ustep"}, bus.ustep, 0);
    chk({tag, "_branch"}, bus.branch_taken, 0);
    chk({tag, "_done"}, bus.instr_done, 0);
    chk({tag, "_illegal"}, bus.illegal_op, 0);
    chk({tag, "_irq_ack"}, ack_s, 0);
  endtask

  // Must be entered on a negedge with the DUT (per model) in FETCH; returns on the
  // negedge of the next FETCH cycle.
  task automatic run_instr(input logic [15:0] ins, input logic [3:0] st, input int gap,
                           input int prob, input int stall_at, input int stall_len,
                           input int irq_mode);
    int   opc, len, t0, prog, held, done_c;
    bit   taken, s, go_irq;
    bit   spat[$];
    bit   ipat[$];
    bit   rpat[$];
    exp_t e;
    opc = int'(ins[15:11]);
    len = ref_len(opc, st, taken);
    for (int i = 0; i < gap; i++) begin
      rand_inputs();
      bus.mem_ready = 1'b0;
      #1;
      chk("fetch_req_wait", bus.fetch_req, 1);
      chk("ir_q_hold", bus.ir_q, last_ir);
      @(negedge clk);
    end
    rand_inputs();
    bus.instr     = ins;
    bus.mem_ready = 1'b1;
    t0 = cyc;

    prog = 0;
    held = 0;
    while (1) begin
      if (stall_at >= 0) s = (prog == stall_at) && (held < stall_len);
      else               s = ($urandom_range(99) < prob);
      if (s) held++;
      spat.push_back(s);
      if (irq_mode == 2)      ipat.push_back(prog >= 2);
      else if (irq_mode == 1) ipat.push_back(1'($urandom_range(1)));
      else                    ipat.push_back(1'b0);
      if (!s) begin
        if (prog == len - 1) break;
        prog++;
      end
    end
    done_c = t0 + 1 + spat.size();
`ifdef CTRL_SEQ_IRQ_EN
    go_irq = ipat[ipat.size()-1];
`else
    go_irq = 1'b0;
`endif
    if (opc >= 16) begin
      e = '{K_ILL, t0 + 1, ins, opc, 1'b0, 0};
      sbq.push_back(e);
    end
    e = '{K_DONE, done_c, ins, opc, taken, len - 1};
    sbq.push_back(e);
    if (go_irq) begin
      prog = 0;
      while (1) begin
        s = (stall_at < 0) && ($urandom_range(99) < prob);
        rpat.push_back(s);
        if (!s) begin
          if (prog == 3) break;
          prog++;
        end
      end
      e = '{K_ACK, done_c + rpat.size(), ins, opc, taken, 3};
      sbq.push_back(e);
    end

    @(negedge clk);
    last_ir = ins;
    rand_inputs();
    bus.status = st;
    for (int k = 0; k < spat.size(); k++) begin
      @(negedge clk);
      rand_inputs();
      bus.stall = spat[k];
      irq_drv   = ipat[k];
    end
    for (int k = 0; k < rpat.size(); k++) begin
      @(negedge clk);
      rand_inputs();
      bus.stall = rpat[k];
      irq_drv   = (irq_mode == 2);
    end
    @(negedge clk);
  endtask

  task automatic reset_mid();
    bus.instr     = {5'd2, 11'h0ab};
    bus.mem_ready = 1'b1;
    bus.stall     = 1'b0;
    irq_drv       = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("ustep_before_reset", bus.ustep, 1);
    #1 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_mid_idle", bus.state, 0);
    @(negedge clk);
    #1 chk("rst_mid_fetch_state", bus.state, 1);
    chk("rst_mid_fetch_req", bus.fetch_req, 1);
    last_ir = '0;
  endtask

  always @(negedge clk) begin
    int   k;
    exp_t e;
    #4;
    if (rst_n && (bus.instr_done || bus.illegal_op || ack_s)) begin
      k = bus.illegal_op ? K_ILL : (bus.instr_done ? K_DONE : K_ACK);
      if (sbq.size() == 0) begin
        chk("unexpected_event", k, 99);
      end else begin
        e = sbq.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("opcode_q", bus.opcode_q, e.opc);
        if (k != K_ILL) begin
          chk("ir_q", bus.ir_q, e.ir);
          chk("branch_taken", bus.branch_taken, e.br);
          chk("ustep_final", bus.ustep, e.us);
        end
      end
    end
  end

  initial begin
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    bus.status    = '0;
    bus.stall     = 1'b0;
    #3 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_idle", bus.state, 0);
    @(negedge clk);
    #1 chk("first_fetch_state", bus.state, 1);
    chk("first_fetch_req", bus.fetch_req, 1);

    run_instr({5'h02, 11'h123}, 4'b0000, 0, 0, -1, 0, 0);
    run_instr({5'h0D, 11'h000}, 4'b0010, 0, 0, -1, 0, 0);
    run_instr({5'h0D, 11'h000}, 4'b0000, 0, 0, -1, 0, 0);
    run_instr({5'h0E, 11'h055}, 4'b1000, 1, 0, -1, 0, 0);
    run_instr({5'h0F, 11'h0aa}, 4'b0100, 0, 0, -1, 0, 0);
    run_instr({5'h07, 11'h000}, 4'b0000, 0, 0, 1, 3, 0);
    run_instr({5'h02, 11'h7ff}, 4'b0000, 0, 0, 2, 2, 0);
    run_instr({5'h00, 11'h321}, 4'b0000, 5, 0, -1, 0, 0);
    run_instr({5'h13, 11'h000}, 4'b1110, 0, 0, -1, 0, 0);
    run_instr({5'h1F, 11'h001}, 4'b0000, 2, 0, -1, 0, 0);
    run_instr({5'h0A, 11'h000}, 4'b0000, 0, 0, -1, 0, 2);
    run_instr({5'h0C, 11'h000}, 4'b0000, 0, 0, -1, 0, 0);

    for (int i = 0; i < 300; i++)
      run_instr(16'($urandom), 4'($urandom), $urandom_range(0, 3), 25, -1, 0, 1);

    reset_mid();

    for (int i = 0; i < 40; i++)
      run_instr(16'($urandom), 4'($urandom), $urandom_range(0, 2), 30, -1, 0, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
